// File: rtl/trigger_gen.sv
// Multi-mode scope-trigger generator: prescaled stimulus counter, debounced switch qualification, fixed-width trig pulse.
// Optional build macro TRIG_AUTO_REARM_EN: HOLD re-enters ARMED instead of IDLE.
module trigger_gen #(
  parameter int NCH      = 5,
  parameter int PRESC    = 4,
  parameter int DEBOUNCE = 4,
  parameter int DELAY    = 1000,
  parameter int PULSE_W  = 4,
  parameter logic [NCH-1:0] MATCH = 'h15
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sw_in,
  input  logic           mode_btn,
  input  logic           arm,
  output logic [NCH-1:0] ch,
  output logic           trig,
  output logic           busy,
  output logic [1:0]     mode,
  output logic           rLed,
  output logic           gLed,
  output logic           bLed
);

  localparam int PSW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam int DBW = $clog2(DEBOUNCE + 1);
  localparam int DLW = $clog2(DELAY + 1);
  localparam int PWW = $clog2(PULSE_W + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_FIRE  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  // Conditioning lanes: index 0 is the trigger switch, index 1 the mode button.
  logic [1:0]     s1_q, s2_q, db_q, db_d, dbp_q;
  logic [DBW-1:0] dbc_q [2];
  logic [DBW-1:0] dbc_d [2];

  logic [PSW-1:0] presc_q, presc_d;
  logic [NCH-1:0] ch_q, ch_d;
  logic [1:0]     state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic           seen_q, seen_d;
  logic [DLW-1:0] dly_q, dly_d;
  logic [PWW-1:0] pcnt_q, pcnt_d;
  logic           trig_q, trig_d;
  logic           busy_q, busy_d;
  logic [2:0]     led_q, led_d;

  logic sw_db, sw_rise, sw_fall, btn_rise, fire;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]  = db_q[i];
      dbc_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (dbc_q[i] == DBW'(DEBOUNCE - 1)) db_d[i] = s2_q[i];
        else                               dbc_d[i] = dbc_q[i] + 1'b1;
      end
    end
  end

  assign sw_db    = db_q[0];
  assign sw_rise  = db_q[0] & ~dbp_q[0];
  assign sw_fall  = ~db_q[0] & dbp_q[0];
  assign btn_rise = db_q[1] & ~dbp_q[1];

  always_comb begin
    presc_d = presc_q + 1'b1;
    ch_d    = ch_q;
    if (presc_q == PSW'(PRESC - 1)) begin
      presc_d = '0;
      ch_d    = ch_q + 1'b1;
    end
  end

  always_comb begin
    case (mode_q)
      2'd0:    fire = seen_q & sw_fall;
      2'd1:    fire = sw_db & (ch_q == MATCH);
      2'd2:    fire = sw_db & (dly_q == DLW'(DELAY - 1));
      default: fire = sw_rise;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    seen_d  = 1'b0;
    dly_d   = '0;
    pcnt_d  = '0;
    case (state_q)
      S_IDLE: begin
        if (btn_rise) mode_d = mode_q + 1'b1;
        if (arm)      state_d = S_ARMED;
      end
      S_ARMED: begin
        seen_d = seen_q | sw_rise;
        if (sw_db) dly_d = (dly_q == DLW'(DELAY)) ? dly_q : dly_q + 1'b1;
        if (fire)  state_d = S_FIRE;
      end
      S_FIRE: begin
        pcnt_d = pcnt_q + 1'b1;
        if (pcnt_q == PWW'(PULSE_W - 1)) begin
          pcnt_d  = '0;
          state_d = S_HOLD;
        end
      end
      default: begin
        if (!sw_db) begin
`ifdef TRIG_AUTO_REARM_EN
          state_d = S_ARMED;
`else
          state_d = S_IDLE;
`endif
        end
      end
    endcase
  end

  // Outputs are registered alongside the state so the probe header sees glitch-free levels.
  always_comb begin
    trig_d = (state_d == S_FIRE);
    busy_d = (state_d != S_IDLE);
    case (mode_d)
      2'd0:    led_d = 3'b100;
      2'd1:    led_d = 3'b010;
      2'd2:    led_d = 3'b001;
      default: led_d = 3'b111;
    endcase
    if (trig_d) led_d = 3'b000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      dbp_q   <= '0;
      dbc_q   <= '{default: '0};
      presc_q <= '0;
      ch_q    <= '0;
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      seen_q  <= 1'b0;
      dly_q   <= '0;
      pcnt_q  <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      led_q   <= 3'b100;
    end else begin
      s1_q    <= {mode_btn, sw_in};
      s2_q    <= s1_q;
      db_q    <= db_d;
      dbp_q   <= db_q;
      dbc_q   <= dbc_d;
      presc_q <= presc_d;
      ch_q    <= ch_d;
      state_q <= state_d;
      mode_q  <= mode_d;
      seen_q  <= seen_d;
      dly_q   <= dly_d;
      pcnt_q  <= pcnt_d;
      trig_q  <= trig_d;
      busy_q  <= busy_d;
      led_q   <= led_d;
    end
  end

  assign ch   = ch_q;
  assign trig = trig_q;
  assign busy = busy_q;
  assign mode = mode_q;
  assign rLed = led_q[2];
  assign gLed = led_q[1];
  assign bLed = led_q[0];

endmodule

// File: tb/tb_trigger_gen.sv
// Directed bench for trigger_gen: reset, SEQ/TIME/COMB/EDGE triggering, mode lockout, reset during FIRE.
module tb_trigger_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_in = 1'b0;
  logic       mode_btn = 1'b0;
  logic       arm = 1'b0;
  logic [4:0] ch;
  logic       trig, busy, rLed, gLed, bLed;
  logic [1:0] mode;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int k;
  int n_trig;

  trigger_gen #(
    .NCH(5), .PRESC(1), .DEBOUNCE(2), .DELAY(8), .PULSE_W(3), .MATCH(5'h15)
  ) dut (
    .clk(clk), .rst(rst), .sw_in(sw_in), .mode_btn(mode_btn), .arm(arm),
    .ch(ch), .trig(trig), .busy(busy), .mode(mode),
    .rLed(rLed), .gLed(gLed), .bLed(bLed)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press_btn();
    mode_btn = 1'b1;
    repeat (6) tick();
    mode_btn = 1'b0;
    repeat (6) tick();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // SEQ press/release; returns the number of cycles trig was seen high.
  task automatic seq_pulse(output int n);
    n = 0;
    sw_in = 1'b1;
    repeat (5) tick();
    sw_in = 1'b0;
    repeat (12) begin
      tick();
      if (trig === 1'b1) n++;
    end
  endtask

  initial begin
    // Reset
    #1 rst = 1'b1;
    #1;
    check("rst_trig", trig, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mode", mode, 2'd0);
    check("rst_led", {rLed, gLed, bLed}, 3'b100);
    check("rst_ch", ch, 5'd0);
    tick(); tick();
    rst = 1'b0;
    cyc = 0;

    // Idle counting with wrap
    check("idle_ch0", ch, 5'd0);
    for (int i = 1; i <= 40; i++) begin
      tick();
      check("idle_ch", ch, cyc % 32);
      check("idle_trig", trig, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_led", {rLed, gLed, bLed}, 3'b100);
    end

    // SEQ: fires on the debounced release
    do_arm();
    check("seq_busy_armed", busy, 1'b1);
    sw_in = 1'b1;
    repeat (5) tick();
    sw_in = 1'b0;
    for (int i = 6; i <= 14; i++) begin
      tick();
      check("seq_trig", trig, (i >= 10 && i <= 12));
      check("seq_busy", busy, (i <= 13));
      check("seq_led", {rLed, gLed, bLed}, (i >= 10 && i <= 12) ? 3'b000 : 3'b100);
    end

    // TIME: short hold does nothing, long hold fires 8 cycles after sw_db rise
    press_btn();
    check("time_mode1", mode, 2'd1);
    press_btn();
    check("time_mode2", mode, 2'd2);
    check("time_led", {rLed, gLed, bLed}, 3'b001);
    do_arm();
    sw_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 6) sw_in = 1'b0;
      check("time_short_trig", trig, 1'b0);
    end
    sw_in = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 12) sw_in = 1'b0;
      check("time_long_trig", trig, (i >= 12 && i <= 14));
    end
    repeat (3) tick();
    check("time_busy_end", busy, 1'b0);

    // COMB: fires in the cycle after ch reaches MATCH while sw is held
    press_btn(); press_btn(); press_btn();
    check("comb_mode", mode, 2'd1);
    check("comb_led_idle", {rLed, gLed, bLed}, 3'b010);
    do_arm();
    sw_in = 1'b1;
    repeat (4) tick();
    k = cyc;
    while ((k % 32) != 21) k++;
    while (cyc < k + 6) begin
      tick();
      check("comb_trig", trig, (cyc >= k + 1 && cyc <= k + 3));
      check("comb_led", {rLed, gLed, bLed}, (cyc >= k + 1 && cyc <= k + 3) ? 3'b000 : 3'b010);
    end
    sw_in = 1'b0;
    repeat (8) tick();
    check("comb_busy_end", busy, 1'b0);

    // EDGE: glitch filtered, mode locked while ARMED, clean press fires
    press_btn(); press_btn();
    check("edge_mode", mode, 2'd3);
    check("edge_led", {rLed, gLed, bLed}, 3'b111);
    do_arm();
    sw_in = 1'b1;
    tick();
    sw_in = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("edge_glitch_trig", trig, 1'b0);
    end
    check("edge_glitch_busy", busy, 1'b1);
    press_btn();
    check("edge_mode_locked", mode, 2'd3);
    sw_in = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("edge_trig", trig, (i >= 5 && i <= 7));
    end
    sw_in = 1'b0;
    repeat (8) tick();
    check("edge_busy_end", busy, 1'b0);

    // Reset asserted during FIRE
    do_arm();
    sw_in = 1'b1;
    repeat (5) tick();
    check("fire_trig_before_rst", trig, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_trig", trig, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_mode", mode, 2'd0);
    check("midrst_led", {rLed, gLed, bLed}, 3'b100);
    check("midrst_ch", ch, 5'd0);
    sw_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("postrst_trig", trig, 1'b0);
      check("postrst_ch", ch, cyc % 32);
    end

    // Re-arm behaviour after HOLD (SEQ mode)
    do_arm();
    seq_pulse(n_trig);
    check("rearm_first_pulse", n_trig, 3);
`ifdef TRIG_AUTO_REARM_EN
    check("rearm_busy", busy, 1'b1);
    seq_pulse(n_trig);
    check("rearm_second_pulse", n_trig, 3);
`else
    check("rearm_busy", busy, 1'b0);
    seq_pulse(n_trig);
    check("rearm_second_pulse", n_trig, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
